// File: rtl/conv_seq_ctrl.sv
// Frame sequencer for the 2D-conv MCU: paces column loads, conv run and column drain; drives {eop,sop}, chblk, row address.
// Latency: all outputs registered, one cycle after the causing event. Optional cycle counter: CONV_SEQ_CYCLE_CNT_EN.
// Backpressure: input words accepted on i_in_valid&o_in_ready; output words held stable while i_out_ready is low.
module conv_seq_ctrl #(
    parameter int N    = 2,
    parameter int ROWS = 8,
    parameter int COLS = 8,
    localparam int ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_proc_done,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_sop,
    output logic              o_eop,
    output logic              o_chblk,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_cycle_cnt
);
    localparam int LL_W = $clog2(N + 2);
    localparam int OC_W = $clog2(COLS + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(ROWS - 1);
    localparam logic [LL_W-1:0]   LOAD_FIRST = LL_W'(N + 1);
    localparam logic [OC_W-1:0]   OUT_COLS   = OC_W'(COLS - N);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CHB_L, S_GAP_L, S_PROC, S_OUT, S_CHB_O, S_GAP_O, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LL_W-1:0]   load_left_q, load_left_d;
    logic [OC_W-1:0]   out_cnt_q, out_cnt_d;
    logic [1:0]        code_q, code_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              chblk_q, chblk_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              in_acc, out_acc;

    assign in_acc  = i_in_valid && in_ready_q;
    assign out_acc = out_valid_q && i_out_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        load_left_d = load_left_q;
        out_cnt_d   = out_cnt_q;
        case (state_q)
            S_IDLE: if (i_start) begin
                state_d     = S_LOAD;
                load_left_d = LOAD_FIRST;
                out_cnt_d   = '0;
            end
            S_LOAD: if (in_acc) begin
                if (addr_q == ADDR_LAST) begin
                    addr_d      = '0;
                    load_left_d = load_left_q - LL_W'(1);
                    state_d     = S_CHB_L;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            // The gap cycle drops chblk so the MCU sees a fresh rising edge on the next pulse.
            S_CHB_L: state_d = S_GAP_L;
            S_GAP_L: state_d = (load_left_q != '0) ? S_LOAD : S_PROC;
            S_PROC: if (i_proc_done) begin
                state_d = S_OUT;
                addr_d  = '0;
            end
            S_OUT: if (out_acc) begin
                if (addr_q == ADDR_LAST) begin
                    addr_d    = '0;
                    out_cnt_d = out_cnt_q + OC_W'(1);
                    state_d   = S_CHB_O;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_CHB_O: state_d = S_GAP_O;
            S_GAP_O: begin
                if (out_cnt_q == OUT_COLS) begin
                    state_d = S_DONE;
                end else begin
                    state_d     = S_LOAD;
                    load_left_d = LL_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they register together with it.
    always_comb begin
        in_ready_d  = (state_d == S_LOAD);
        out_valid_d = (state_d == S_OUT);
        chblk_d     = (state_d == S_CHB_L) || (state_d == S_CHB_O);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        case (state_d)
            S_LOAD, S_CHB_L, S_GAP_L: code_d = 2'b00;
            S_PROC:                   code_d = 2'b01;
            S_OUT, S_CHB_O, S_GAP_O:  code_d = 2'b10;
            default:                  code_d = 2'b11;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            load_left_q <= '0;
            out_cnt_q   <= '0;
            code_q      <= 2'b11;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            chblk_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            load_left_q <= load_left_d;
            out_cnt_q   <= out_cnt_d;
            code_q      <= code_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            chblk_q     <= chblk_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_in_ready  = in_ready_q;
    assign o_out_valid = out_valid_q;
    assign o_addr      = addr_q;
    assign o_sop       = code_q[0];
    assign o_eop       = code_q[1];
    assign o_chblk     = chblk_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

`ifdef CONV_SEQ_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Counts every non-IDLE cycle including DONE, so it holds once back in IDLE.
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == S_IDLE) begin
            if (i_start) cyc_d = '0;
        end else if (cyc_q != 32'hFFFF_FFFF) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cyc_q <= '0;
        else      cyc_q <= cyc_d;
    end

    assign o_cycle_cnt = cyc_q;
`else
    assign o_cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: randomized frames compared against an expected event trace built from the frame rules.
module tb_conv_seq_ctrl;
    localparam int N      = 2;
    localparam int ROWS   = 4;
    localparam int COLS   = 5;
    localparam int OUTC   = COLS - N;
    localparam int ADDR_W = $clog2(ROWS);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_start = 1'b0;
    logic              i_in_valid = 1'b0;
    logic              o_in_ready;
    logic              i_proc_done = 1'b0;
    logic              o_out_valid;
    logic              i_out_ready = 1'b0;
    logic [ADDR_W-1:0] o_addr;
    logic              o_sop, o_eop, o_chblk, o_busy, o_done;
    logic [31:0]       o_cycle_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    conv_seq_ctrl #(.N(N), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_proc_done(i_proc_done), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_addr(o_addr), .o_sop(o_sop), .o_eop(o_eop), .o_chblk(o_chblk), .o_busy(o_busy),
        .o_done(o_done), .o_cycle_cnt(o_cycle_cnt)
    );

    // Event word: type (1 IN, 2 CHBLK, 3 PROC, 4 OUT, 5 DONE), phase code, value (addr or run length).
    function automatic int ev(input int t, input int code, input int val);
        return (t << 16) | (code << 8) | val;
    endfunction

    task automatic run_frame(input int vpct, input bit vtog, input int rpct, input int pdmin,
                             input int pdmax, input bit poke, input bit stall, input string name);
        int exp_q[$];
        int obs_q[$];
        int pd[OUTC];
        int busy_cnt = 0, chw = 0, chcode = 0, dw = 0, dcode = 0, pc = 0, pidx = 0, cyc = 0;
        int n_chb = 0, n_done = 0, n_in = 0, n_out = 0, stall_left = 0, stall_bad = 0;
        int exp_cyc;
        bit fin = 0, stalled = 0;
        logic [1:0] code;

        for (int k = 0; k < OUTC; k++) pd[k] = int'($urandom_range(pdmax, pdmin));
        for (int c = 0; c <= N; c++) begin
            for (int a = 0; a < ROWS; a++) exp_q.push_back(ev(1, 0, a));
            exp_q.push_back(ev(2, 0, 1));
        end
        for (int k = 0; k < OUTC; k++) begin
            exp_q.push_back(ev(3, 1, pd[k] + 1));
            for (int a = 0; a < ROWS; a++) exp_q.push_back(ev(4, 2, a));
            exp_q.push_back(ev(2, 2, 1));
            if (k < OUTC - 1) begin
                for (int a = 0; a < ROWS; a++) exp_q.push_back(ev(1, 0, a));
                exp_q.push_back(ev(2, 0, 1));
            end
        end
        exp_q.push_back(ev(5, 3, 1));

        @(negedge clk);
        i_start = 1'b1;
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            code = {o_eop, o_sop};
            if (o_busy) busy_cnt++;
            if (o_chblk) begin
                if (chw == 0) chcode = int'(code);
                chw++;
            end else if (chw > 0) begin
                obs_q.push_back(ev(2, chcode, chw));
                n_chb++;
                chw = 0;
            end
            if (code == 2'b01) pc++;
            else if (pc > 0) begin
                obs_q.push_back(ev(3, 1, pc));
                pc = 0;
                pidx++;
            end
            if (o_done) begin
                if (dw == 0) dcode = int'(code);
                dw++;
            end else if (dw > 0) begin
                obs_q.push_back(ev(5, dcode, dw));
                n_done++;
                fin = 1;
            end

            i_start    = poke && (code == 2'b01);
            i_in_valid = vtog ? (cyc % 2 == 1) : (int'($urandom_range(0, 99)) < vpct);
            if (o_in_ready && i_in_valid) begin
                obs_q.push_back(ev(1, int'(code), int'(o_addr)));
                n_in++;
            end
            if (stall && !stalled && o_out_valid && o_addr == 2) begin
                stalled = 1;
                stall_left = 10;
            end
            if (stall_left > 0) begin
                if (o_out_valid !== 1'b1 || o_addr !== 2'd2) stall_bad++;
                i_out_ready = 1'b0;
                stall_left--;
            end else begin
                i_out_ready = (int'($urandom_range(0, 99)) < rpct);
            end
            if (o_out_valid && i_out_ready) begin
                obs_q.push_back(ev(4, int'(code), int'(o_addr)));
                n_out++;
            end
            if (code == 2'b01) i_proc_done = (pidx < OUTC) ? (pc > pd[pidx]) : 1'b1;
            else               i_proc_done = ($urandom_range(0, 3) == 0);
        end
        i_start = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0; i_proc_done = 1'b0;

        tests++;
        if (!fin) begin
            fails++;
            $display("FAIL %s timeout: frame did not end within %0d cycles, required done", name, cyc);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s trace_len got %0d expected %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL %s trace[%0d] got %h expected %h", name, i,
                         (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
                break;
            end
        end
        tests++;
        if (n_chb != COLS + OUTC) begin
            fails++;
            $display("FAIL %s chblk_count got %0d expected %0d", name, n_chb, COLS + OUTC);
        end
        tests++;
        if (n_done != 1) begin
            fails++;
            $display("FAIL %s done_count got %0d expected 1", name, n_done);
        end
        tests++;
        if (n_in != COLS * ROWS || n_out != OUTC * ROWS) begin
            fails++;
            $display("FAIL %s word_counts got in=%0d out=%0d expected in=%0d out=%0d",
                     name, n_in, n_out, COLS * ROWS, OUTC * ROWS);
        end
        if (stall) begin
            tests++;
            if (!stalled || stall_bad != 0) begin
                fails++;
                $display("FAIL %s out_stall got stalled=%0d bad_cycles=%0d expected stalled=1 bad_cycles=0",
                         name, stalled, stall_bad);
            end
        end
`ifdef CONV_SEQ_CYCLE_CNT_EN
        exp_cyc = busy_cnt;
`else
        exp_cyc = 0;
`endif
        tests++;
        if (o_busy !== 1'b0 || o_cycle_cnt !== 32'(exp_cyc)) begin
            fails++;
            $display("FAIL %s end_state got busy=%b cycle_cnt=%0d expected busy=0 cycle_cnt=%0d",
                     name, o_busy, o_cycle_cnt, exp_cyc);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (o_cycle_cnt !== 32'(exp_cyc)) begin
            fails++;
            $display("FAIL %s cycle_cnt_frozen got %0d expected %0d", name, o_cycle_cnt, exp_cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({o_eop, o_sop} !== 2'b11 || o_chblk !== 1'b0 || o_addr !== '0) begin
            fails++;
            $display("FAIL reset_code_chblk_addr got code=%b chblk=%b addr=%0d expected 11 0 0",
                     {o_eop, o_sop}, o_chblk, o_addr);
        end
        tests++;
        if (o_in_ready !== 1'b0 || o_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake got ready=%b valid=%b expected 0 0", o_in_ready, o_out_valid);
        end
        tests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_cycle_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_status got busy=%b done=%b cnt=%0d expected 0 0 0", o_busy, o_done, o_cycle_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_frame(100, 0, 100, 3, 3, 0, 0, "basic");
    endtask

    task automatic test_midrun_reset();
        int bad = 0;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_in_valid = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({o_eop, o_sop} !== 2'b11 || o_chblk !== 1'b0 || o_addr !== '0 || o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset got code=%b chblk=%b addr=%0d busy=%b ready=%b expected 11 0 0 0 0",
                     {o_eop, o_sop}, o_chblk, o_addr, o_busy, o_in_ready);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if ({o_eop, o_sop} !== 2'b11 || o_chblk !== 1'b0 || o_addr !== '0 || o_busy !== 1'b0 ||
                o_in_ready !== 1'b0 || o_out_valid !== 1'b0 || o_done !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midrun_reset_hold got %0d unstable cycles expected 0", bad);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL midrun_no_resume got busy=%b ready=%b expected 0 0", o_busy, o_in_ready);
        end
        i_in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_in_toggle();
        run_frame(0, 1, 100, 0, 2, 0, 0, "in_toggle");
    endtask

    task automatic test_out_stall();
        run_frame(100, 0, 100, 1, 1, 0, 1, "out_stall");
    endtask

    task automatic test_start_ignored();
        run_frame(100, 0, 100, 4, 4, 1, 0, "start_in_proc");
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++)
            run_frame(int'($urandom_range(30, 100)), 0, int'($urandom_range(30, 100)), 0, 5,
                      1'($urandom_range(0, 1)), 0, "random");
    endtask

    task automatic test_back_to_back();
        run_frame(90, 0, 90, 0, 2, 0, 0, "b2b_first");
        run_frame(70, 0, 60, 0, 3, 0, 0, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_midrun_reset();
        test_in_toggle();
        test_out_stall();
        test_start_ignored();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog expired");
    end
endmodule
